// File: rtl/ending_sequencer.sv
// End-of-game screen: fades the selected ending image in, holds it, waits for restart, then fades it out.
// Latency: 2 cycles from x_pos/y_pos to pixel_out (1 cycle to rom_addr); FSM reacts on the edge after its inputs.
// Backpressure: none; the pixel pipeline free-runs and the FSM only advances on frame_start or restart edges.
module ending_sequencer #(
    parameter int IMG_W       = 168,
    parameter int IMG_H       = 49,
    parameter int FADE_FRAMES = 2,
    parameter int HOLD_FRAMES = 120
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic        game_over,
    input  logic        winner,
    input  logic        frame_start,
    input  logic        restart_btn,
    input  logic [8:0]  x_pos,
    input  logic [6:0]  y_pos,
    output logic [14:0] rom_addr,
    input  logic [23:0] rom_q,
    output logic        ending_active,
    output logic        ending_type,
    output logic [23:0] pixel_out,
    output logic        done
);

    localparam int CNT_MAX = (FADE_FRAMES > HOLD_FRAMES) ? FADE_FRAMES : HOLD_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [9:0]  X_LIM     = 10'(2 * IMG_W);
    localparam logic [7:0]  Y_LIM     = 8'(2 * IMG_H);
    localparam logic [14:0] IMG1_BASE = 15'(IMG_W * IMG_H);

    typedef enum logic [2:0] {
        IDLE,
        FADE_IN,
        HOLD,
        WAIT_RESTART,
        FADE_OUT
    } state_t;

    state_t           state;
    logic [4:0]       level;
    logic [CNT_W-1:0] frame_cnt;
    logic             restart_q;
    logic             fade_step;
    logic             hold_last;
    logic             restart_edge;

    logic [14:0]      addr_next;
    logic             in_range;
    logic             in_range_q;
    logic [4:0]       level_q;

    assign fade_step     = frame_start && (frame_cnt == CNT_W'(FADE_FRAMES - 1));
    assign hold_last     = frame_start && (frame_cnt == CNT_W'(HOLD_FRAMES - 1));
    assign restart_edge  = restart_btn && !restart_q;
    assign ending_active = (state != IDLE);

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state       <= IDLE;
            level       <= 5'd0;
            frame_cnt   <= '0;
            restart_q   <= 1'b0;
            ending_type <= 1'b0;
            done        <= 1'b0;
        end else begin
            restart_q <= restart_btn;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (game_over) begin
                        ending_type <= winner;
                        level       <= 5'd0;
                        frame_cnt   <= '0;
                        state       <= FADE_IN;
                    end
                end
                FADE_IN: begin
                    if (fade_step) begin
                        frame_cnt <= '0;
                        level     <= level + 5'd1;
                        if (level == 5'd15) state <= HOLD;
                    end else if (frame_start) begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (hold_last) begin
                        frame_cnt <= '0;
                        state     <= WAIT_RESTART;
                    end else if (frame_start) begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
                WAIT_RESTART: begin
                    // restart_q tracks the button in every state, so a press held since HOLD is not an edge
                    if (restart_edge) begin
                        frame_cnt <= '0;
                        state     <= FADE_OUT;
                    end
                end
                FADE_OUT: begin
                    if (fade_step) begin
                        frame_cnt <= '0;
                        level     <= level - 5'd1;
                        if (level == 5'd1) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end else if (frame_start) begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    function automatic logic [7:0] scale(input logic [7:0] c, input logic [4:0] lv);
        logic [12:0] p;
        p = 13'(c) * 13'(lv);
        return 8'(p >> 4);
    endfunction

    // Memory holds pixels at half resolution; each stored pixel covers a 2x2 screen block.
    assign addr_next = 15'(y_pos[6:1]) * 15'(IMG_W) + 15'(x_pos[8:1])
                     + (ending_type ? IMG1_BASE : 15'd0);
    assign in_range  = ({1'b0, x_pos} < X_LIM) && ({1'b0, y_pos} < Y_LIM);

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            rom_addr   <= 15'd0;
            in_range_q <= 1'b0;
            level_q    <= 5'd0;
            pixel_out  <= 24'd0;
        end else begin
            rom_addr   <= addr_next;
            in_range_q <= in_range;
            level_q    <= level;
            pixel_out  <= in_range_q ? {scale(rom_q[23:16], level_q),
                                        scale(rom_q[15:8],  level_q),
                                        scale(rom_q[7:0],   level_q)} : 24'd0;
        end
    end

endmodule

// File: tb/tb_ending_sequencer.sv
// Directed bench for ending_sequencer; expected values queued at stimulus time and popped at output time.
module tb_ending_sequencer;

    logic        vga_clk = 1'b0;
    logic        reset;
    logic        game_over;
    logic        winner;
    logic        frame_start;
    logic        restart_btn;
    logic [8:0]  x_pos;
    logic [6:0]  y_pos;
    logic [14:0] rom_addr;
    logic [23:0] rom_q;
    logic        ending_active;
    logic        ending_type;
    logic [23:0] pixel_out;
    logic        done;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    always #5 vga_clk = ~vga_clk;

    ending_sequencer dut (
        .vga_clk       (vga_clk),
        .reset         (reset),
        .game_over     (game_over),
        .winner        (winner),
        .frame_start   (frame_start),
        .restart_btn   (restart_btn),
        .x_pos         (x_pos),
        .y_pos         (y_pos),
        .rom_addr      (rom_addr),
        .rom_q         (rom_q),
        .ending_active (ending_active),
        .ending_type   (ending_type),
        .pixel_out     (pixel_out),
        .done          (done)
    );

    task automatic tick();
        @(negedge vga_clk);
    endtask

    task automatic settle();
        repeat (2) tick();
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, obs);
        end else begin
            chk(tag, obs, exp_q.pop_front());
        end
    endtask

    function automatic logic [23:0] px(input logic [23:0] c, input int lv);
        int r, g, b;
        r = (int'(c[23:16]) * lv) / 16;
        g = (int'(c[15:8])  * lv) / 16;
        b = (int'(c[7:0])   * lv) / 16;
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lv;
        reset       = 1'b1;
        game_over   = 1'b0;
        winner      = 1'b0;
        frame_start = 1'b0;
        restart_btn = 1'b0;
        x_pos       = 9'd0;
        y_pos       = 7'd0;
        rom_q       = 24'hFF8040;

        // Reset state
        repeat (2) tick();
        chk("rst_active",   32'(ending_active), 32'd0);
        chk("rst_type",     32'(ending_type),   32'd0);
        chk("rst_addr",     32'(rom_addr),      32'd0);
        chk("rst_pixel",    32'(pixel_out),     32'd0);
        chk("rst_done",     32'(done),          32'd0);
        reset = 1'b0;

        // Address with image 0 selected
        x_pos = 9'd10; y_pos = 7'd4;
        push_exp(32'd341);
        tick();
        pop_chk("addr_img0", 32'(rom_addr));
        x_pos = 9'd0; y_pos = 7'd0;

        // Reset mid-fade
        game_over = 1'b1; winner = 1'b1;
        tick();
        game_over = 1'b0; winner = 1'b0;
        chk("go_active", 32'(ending_active), 32'd1);
        chk("go_type",   32'(ending_type),   32'd1);
        repeat (5) frame();
        push_exp(32'(px(rom_q, 2)));
        settle();
        pop_chk("midfade_px", 32'(pixel_out));
        reset = 1'b1;
        tick();
        chk("midrst_active", 32'(ending_active), 32'd0);
        chk("midrst_pixel",  32'(pixel_out),     32'd0);
        chk("midrst_type",   32'(ending_type),   32'd0);
        reset = 1'b0;
        settle();
        chk("idle_pixel", 32'(pixel_out), 32'd0);

        // Fade in (winner 1 latched for later address and ignore checks)
        game_over = 1'b1; winner = 1'b1;
        tick();
        game_over = 1'b0; winner = 1'b0;
        lv = 0;
        for (int k = 1; k <= 32; k++) begin
            frame();
            if (k % 2 == 0) lv++;
            push_exp(32'(px(rom_q, lv)));
            settle();
            pop_chk("fade_in_px", 32'(pixel_out));
            if (k == 16) chk("lvl8_px",  32'(pixel_out), 32'h7F4020);
            if (k == 32) chk("lvl16_px", 32'(pixel_out), 32'hFF8040);
        end

        // Hold, button held throughout
        restart_btn = 1'b1;
        game_over = 1'b1; winner = 1'b0;
        tick();
        game_over = 1'b0;
        tick();
        chk("hold_go_type",   32'(ending_type),   32'd1);
        chk("hold_go_active", 32'(ending_active), 32'd1);
        settle();
        chk("hold_go_px", 32'(pixel_out), 32'hFF8040);

        x_pos = 9'd10; y_pos = 7'd4;
        push_exp(32'd8573);
        tick();
        pop_chk("addr_img1", 32'(rom_addr));
        x_pos = 9'd340; y_pos = 7'd0;
        push_exp(32'd0);
        settle();
        pop_chk("oob_px", 32'(pixel_out));
        x_pos = 9'd0;

        for (int k = 0; k < 120; k++) frame();
        // Now in WAIT_RESTART with button still held: frames must not fade
        repeat (3) frame();
        push_exp(32'hFF8040);
        settle();
        pop_chk("held_btn_px", 32'(pixel_out));

        // Release, then press coincident with frame_start
        restart_btn = 1'b0;
        tick();
        restart_btn = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        frame();
        push_exp(32'(px(rom_q, 16)));
        settle();
        pop_chk("fo_cnt_clr_px", 32'(pixel_out));
        frame();
        push_exp(32'(px(rom_q, 15)));
        settle();
        pop_chk("fo_first_step", 32'(pixel_out));
        chk("fo_no_done", 32'(done), 32'd0);

        // Fade out to completion; game_over on the final frame must be ignored
        lv = 15;
        for (int k = 1; k <= 30; k++) begin
            if (k == 30) begin
                game_over = 1'b1;
                winner = 1'b0;
            end
            frame();
            game_over = 1'b0;
            chk("fo_done_pulse", 32'(done), (k == 30) ? 32'd1 : 32'd0);
            if (k % 2 == 0) lv--;
            push_exp(32'(px(rom_q, lv)));
            settle();
            pop_chk("fade_out_px", 32'(pixel_out));
            chk("fo_done_low", 32'(done), 32'd0);
        end
        chk("end_active", 32'(ending_active), 32'd0);
        chk("end_type",   32'(ending_type),   32'd1);

        // IDLE accepts a new game_over
        game_over = 1'b1; winner = 1'b0;
        tick();
        game_over = 1'b0;
        chk("regame_type",   32'(ending_type),   32'd0);
        chk("regame_active", 32'(ending_active), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ending_sequencer.md
Name: ending_sequencer

Overview:
- Controls the end-of-game screen. On a game-over pulse it latches the winner and fades the ending image in. It holds the image for a fixed time, then waits for a restart press and fades back out.
- Generates the address for the ending image memory and scales the returned RGB by the current fade level.
- Sits between the game-state logic, the ending image memory and the VGA pixel mux.

Parameters:
- IMG_W, 168, stored image width in memory pixels (displayed width 2*IMG_W).
- IMG_H, 49, stored image height in memory rows (displayed height 2*IMG_H).
- FADE_FRAMES, 2, frames per fade step.
- HOLD_FRAMES, 120, frames to hold at full brightness before restart is accepted.

Ports:
- vga_clk  in  1  pixel clock, sole clock.
- reset  in  1  synchronous, active-high reset.
- game_over  in  1  one-cycle pulse at end of game.
- winner  in  1  ending image select; sampled with game_over (0 = image 0, 1 = image 1).
- frame_start  in  1  one-cycle pulse at the start of each frame.
- restart_btn  in  1  level from debounced button.
- x_pos  in  9  current pixel x.
- y_pos  in  7  current pixel y.
- rom_addr  out  15  address to the ending image memory.
- rom_q  in  24  memory data, valid exactly one cycle after rom_addr.
- ending_active  out  1  high in every state except IDLE.
- ending_type  out  1  latched winner.
- pixel_out  out  24  scaled RGB {R[23:16],G[15:8],B[7:0]}.
- done  out  1  one-cycle pulse when fade-out completes.

Behaviour:
- Reset values:
  - state = IDLE, level = 0, frame counter = 0.
  - ending_active = 0, ending_type = 0, rom_addr = 0, pixel_out = 0, done = 0.
  - All pipeline registers are cleared.
  - Reset asserted in any state, including mid-fade, forces these values on the next edge.
- States: IDLE, FADE_IN, HOLD, WAIT_RESTART, FADE_OUT.
- IDLE:
  - game_over = 1 latches ending_type <= winner, sets level = 0 and frame counter = 0, then goes to FADE_IN.
  - game_over in any other state is ignored, and ending_type is unchanged.
- FADE_IN:
  - Each frame_start increments the frame counter.
  - When the counter reaches FADE_FRAMES-1 on a frame_start, the counter clears and level increments.
  - When level becomes 16, go to HOLD with the counter cleared.
- HOLD:
  - Each frame_start increments the counter.
  - On the frame_start where the counter equals HOLD_FRAMES-1, go to WAIT_RESTART.
  - restart_btn is ignored in HOLD.
- WAIT_RESTART:
  - A rising edge of restart_btn goes to FADE_OUT with the counter cleared.
  - The rising edge is detected against a registered copy of restart_btn; that copy is updated in every state.
  - A button already held on entry does not trigger; it must be released and pressed again.
- FADE_OUT:
  - Same stepping as FADE_IN, but level decrements.
  - When level becomes 0, go to IDLE and pulse done for exactly one cycle.
- Simultaneous events:
  - frame_start and the restart edge in the same cycle: the transition to FADE_OUT takes priority, and the counter clears.
  - game_over in the same cycle as the done pulse has no effect (the FSM is not yet in IDLE).
- Level arithmetic:
  - level is 5 bits with range 0..16.
  - Each channel is computed as out = (c * level) >> 4, using a 13-bit product truncated to 8 bits.
  - level 16 reproduces the input exactly; level 0 gives black.
- Pipeline, with a fixed total latency of 2 cycles from x_pos/y_pos to pixel_out:
  - Stage 1: register rom_addr = (y_pos>>1)*IMG_W + (x_pos>>1) + (ending_type ? IMG_W*IMG_H : 0).
  - Stage 1 also registers the in-range flag (x_pos < 2*IMG_W and y_pos < 2*IMG_H) and the current level.
  - Stage 2: register pixel_out = in-range ? scale(rom_q, level) : 0.
  - The pipeline runs continuously; the level captured at stage 1 travels with its pixel.
  - In IDLE, pixel_out is 0 because level is 0.
- Address width rule: with defaults the maximum address is 48*168 + 167 + 8232 = 16463, which fits in 15 bits.

Test Plan:
- Reset mid-fade: game_over with winner = 1, then 5 frame_starts, then reset -> next cycle state IDLE, level 0, ending_active 0, pixel_out 0.
- Fade-in timing:
  - Stimulus: FADE_FRAMES = 2; game_over with winner = 0, then frame_starts.
  - Response: level reaches 1 after the 2nd frame_start and 16 after the 32nd; the FSM enters HOLD.
  - Check pixel_out for rom_q = 24'hFF8040: 24'h7F4020 at level 8 and 24'hFF8040 at level 16.
- Hold and restart:
  - restart_btn held high throughout HOLD -> FSM stays in WAIT_RESTART until the button goes low and then high.
  - The FADE_OUT transition happens one cycle after the rising edge.
- Fade-out completion: from FADE_OUT, 32 frame_starts with FADE_FRAMES = 2 -> level 0, FSM returns to IDLE, done high for exactly 1 cycle.
- Addressing, winner = 1:
  - x_pos = 10, y_pos = 4 -> rom_addr = 2*168 + 5 + 8232 = 8573, one cycle later.
  - x_pos = 340 -> pixel_out = 0 two cycles later, regardless of rom_q.
- Ignored inputs:
  - game_over with winner = 0 during HOLD after winner = 1 was latched -> ending_type stays 1 and the state is unchanged.
  - frame_start coincident with the restart edge -> enters FADE_OUT with the counter at 0.
